pid_update_scheduler: RTL
=========================

Name: pid_update_scheduler

Overview:
- Time-multiplexes one shared MSJ-platform PID datapath across NUMBER_OF_MOTORS motors.
- Each sweep is triggered by a programmable period tick. For every enabled motor, in index order, the block:
  - drives motor_select so the top level muxes that motor's gains, setpoint and feedback into the PID;
  - raises update_controller, which the PID acts on at its rising edge;
  - waits LATENCY cycles;
  - captures the PID's duty into a per-motor output register.
- Sits between the Avalon register bank and the PWM generators.

Parameters:
- NUMBER_OF_MOTORS, 6: motors served per sweep (1..16).
- MOTOR_BITS, 4: width of motor_select (must satisfy 2^MOTOR_BITS >= NUMBER_OF_MOTORS).
- LATENCY, 2: cycles update_controller is held high before duty_in is sampled (>=2).

Ports:
- clock, in, 1: system clock.
- reset_n, in, 1: asynchronous, active-low reset.
- enable, in, 1: run scheduler.
- update_period, in, 32: tick period in clock cycles; 0 means hold in IDLE.
- motor_enable, in, NUMBER_OF_MOTORS: per-motor service enable.
- zero_speed, in, 32 signed: value loaded into a disabled motor's duty register.
- duty_in, in, 32 signed: duty output of the shared PID.
- clear_overrun, in, 1: clears the overrun flag.
- motor_select, out, MOTOR_BITS: index currently routed to the PID.
- update_controller, out, 1: PID update strobe (level).
- duty_out, out, 32*NUMBER_OF_MOTORS: flat vector; motor i occupies bits [32i+31:32i].
- sweep_done, out, 1: one-cycle pulse after the last motor of a sweep.
- busy, out, 1: high while a sweep is in progress.
- overrun, out, 1: sticky; a tick arrived while busy.

Behaviour:
- Reset (asynchronous, reset_n=0): all outputs and duty registers 0, state IDLE, period counter 0, index 0.
- Period counter:
  - Counts while enable=1 and update_period!=0.
  - Tick when counter==update_period-1; the counter then wraps to 0.
  - Cleared to 0 whenever enable=0 or update_period==0.
- Tick while busy:
  - The tick is dropped, not queued.
  - overrun is set to 1.
  - If clear_overrun and a tick-while-busy occur in the same cycle, set wins.
- States:
  - IDLE: update_controller=0. Go to SETUP with index 0 on a tick.
  - SETUP (1 cycle):
    - motor_select=index, update_controller=0.
    - If motor_enable[index]=0: duty_out[index]<=zero_speed, then advance index (see NEXT rule) directly.
    - Otherwise go to PULSE with the pulse counter cleared.
  - PULSE (LATENCY cycles): update_controller=1, motor_select held.
  - CAPTURE (1 cycle): update_controller=0, duty_out[index]<=duty_in, then advance.
  - NEXT rule:
    - If index==NUMBER_OF_MOTORS-1: pulse sweep_done and go to IDLE.
    - Otherwise index+1, go to SETUP.
- update_controller is low for at least 2 cycles between rising edges (CAPTURE+SETUP), so each edge is guaranteed to be detected.
- Sweep length = E*(LATENCY+2) + D cycles, where E is the number of enabled motors and D the number of disabled ones.
- busy=1 from the first SETUP through the final CAPTURE/SETUP.
- busy=0 in the sweep_done cycle, so a tick in that cycle starts a new sweep.
- enable dropping mid-sweep: the current motor completes through CAPTURE (or SETUP if disabled), then the block goes to IDLE without sweep_done. Remaining motors keep their old duty.
- motor_enable is sampled per motor in its SETUP cycle.
- update_period is sampled continuously.
- duty_out registers change only in the CAPTURE or SETUP cycle of their own motor.

Test Plan:
1. Reset: reset_n=0 mid-PULSE -> update_controller=0, duty_out=0, busy=0 immediately; after release, idle until first tick.
2. Basic sweep: N=4, LATENCY=2, period=100, all enabled, duty_in=100+motor_select*10 -> duty_out={130,120,110,100}; sweep_done 16 cycles after sweep start; ticks every 100 cycles.
3. Disabled motor: motor_enable=4'b1011, zero_speed=-5 -> duty_out[2]=-5, no update_controller pulse for index 2, sweep length 13 cycles.
4. Overrun: period=10 with 16-cycle sweep -> overrun=1, every other tick dropped; clear_overrun pulse while idle -> overrun=0.
5. Mid-sweep disable: enable=0 during motor 1 PULSE -> motor 1 captured, motors 2-3 unchanged, no sweep_done, counter=0.
6. Edge spacing: random enables and period=update_period minimum (sweep length) -> update_controller never high in consecutive motors without >=2 low cycles; period=0 -> never leaves IDLE.

Source files
------------

// File: rtl/pid_update_scheduler_if.sv
// Signal bundle between the register bank / shared PID and the PID update scheduler.
// Inputs to the scheduler: enable, update_period, motor_enable, zero_speed, duty_in, clear_overrun.
// Outputs from the scheduler: motor_select, update_controller, duty_out (flat, 32 bits per motor), sweep_done, busy, overrun.
interface pid_update_scheduler_if #(
  parameter int NUMBER_OF_MOTORS = 6,
  parameter int MOTOR_BITS       = 4
);
  logic                            enable;
  logic [31:0]                     update_period;
  logic [NUMBER_OF_MOTORS-1:0]     motor_enable;
  logic signed [31:0]              zero_speed;
  logic signed [31:0]              duty_in;
  logic                            clear_overrun;
  logic [MOTOR_BITS-1:0]           motor_select;
  logic                            update_controller;
  logic [32*NUMBER_OF_MOTORS-1:0]  duty_out;
  logic                            sweep_done;
  logic                            busy;
  logic                            overrun;

  // master: register bank + PID side
  modport master (
    output enable, update_period, motor_enable, zero_speed, duty_in, clear_overrun,
    input  motor_select, update_controller, duty_out, sweep_done, busy, overrun
  );

  // slave: the scheduler itself
  modport slave (
    input  enable, update_period, motor_enable, zero_speed, duty_in, clear_overrun,
    output motor_select, update_controller, duty_out, sweep_done, busy, overrun
  );
endinterface

// File: rtl/pid_update_scheduler.sv
// Purpose: time-multiplexes one shared PID across NUMBER_OF_MOTORS motors, one sweep per period tick.
// Latency: per enabled motor LATENCY+2 cycles (SETUP, PULSE x LATENCY, CAPTURE); per disabled motor 1 cycle.
// Backpressure: none; a tick arriving mid-sweep is dropped and flagged on the sticky overrun bit.
// Ports: clock, reset_n (async active-low), bus (slave modport of pid_update_scheduler_if).
module pid_update_scheduler #(
  parameter int NUMBER_OF_MOTORS = 6,
  parameter int MOTOR_BITS       = 4,
  parameter int LATENCY          = 2
) (
  input logic                   clock,
  input logic                   reset_n,
  pid_update_scheduler_if.slave bus
);

  localparam int                    PW   = $clog2(LATENCY + 1);
  localparam logic [MOTOR_BITS-1:0] LAST = MOTOR_BITS'(NUMBER_OF_MOTORS - 1);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, CAPTURE} state_t;

  state_t                state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [MOTOR_BITS-1:0] idx_q, idx_d;
  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic                  sweep_done_q, sweep_done_d;
  logic                  overrun_q, overrun_d;
  logic signed [31:0]    duty_q [NUMBER_OF_MOTORS];

  logic                  run;
  logic                  tick;
  logic                  busy;
  logic                  sel_en;
  logic                  advance;
  logic                  duty_we;
  logic signed [31:0]    duty_wdat;

  assign run  = bus.enable && (bus.update_period != 32'd0);
  assign tick = run && (cnt_q == bus.update_period - 32'd1);
  assign busy = (state_q != IDLE);

  // Period counter: free-runs while enabled with a nonzero period, wraps on tick.
  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (!run || tick) cnt_d = 32'd0;
  end

  // Per-motor enable for the current index (loop avoids an over-wide bit select).
  always_comb begin
    sel_en = 1'b0;
    for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
      if (idx_q == MOTOR_BITS'(i)) sel_en = bus.motor_enable[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pcnt_d       = pcnt_q;
    sweep_done_d = 1'b0;
    duty_we      = 1'b0;
    duty_wdat    = bus.duty_in;
    advance      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SETUP;
          idx_d   = '0;
        end
      end
      SETUP: begin
        if (sel_en) begin
          state_d = PULSE;
          pcnt_d  = '0;
        end else begin
          duty_we   = 1'b1;
          duty_wdat = bus.zero_speed;
          advance   = 1'b1;
        end
      end
      PULSE: begin
        if (pcnt_q == PW'(LATENCY - 1)) state_d = CAPTURE;
        else                            pcnt_d  = pcnt_q + PW'(1);
      end
      CAPTURE: begin
        duty_we = 1'b1;
        advance = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A dropped enable ends the sweep after the current motor, with no done pulse.
    if (advance) begin
      if (!bus.enable) begin
        state_d = IDLE;
        idx_d   = '0;
      end else if (idx_q == LAST) begin
        state_d      = IDLE;
        idx_d        = '0;
        sweep_done_d = 1'b1;
      end else begin
        state_d = SETUP;
        idx_d   = idx_q + MOTOR_BITS'(1);
      end
    end
  end

  // Set beats clear when both happen in the same cycle.
  always_comb begin
    overrun_d = overrun_q;
    if (bus.clear_overrun) overrun_d = 1'b0;
    if (tick && busy)      overrun_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= 32'd0;
      idx_q        <= '0;
      pcnt_q       <= '0;
      sweep_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < NUMBER_OF_MOTORS; i++) duty_q[i] <= 32'sd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pcnt_q       <= pcnt_d;
      sweep_done_q <= sweep_done_d;
      overrun_q    <= overrun_d;
      for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
        if (duty_we && (idx_q == MOTOR_BITS'(i))) duty_q[i] <= duty_wdat;
      end
    end
  end

  assign bus.motor_select      = idx_q;
  assign bus.update_controller = (state_q == PULSE);
  assign bus.sweep_done        = sweep_done_q;
  assign bus.busy              = busy;
  assign bus.overrun           = overrun_q;

  for (genvar g = 0; g < NUMBER_OF_MOTORS; g++) begin : g_duty
    assign bus.duty_out[32*g +: 32] = duty_q[g];
  end

endmodule
